// File: rtl/bp_cce_cfg_link_slave.sv
// Config-link endpoint for the CCE: pairs lo/hi half-word config writes into
// instruction RAM writes, serves half-word readback and holds the mode bit.
module bp_cce_cfg_link_slave #(
  parameter int inst_width_p          = 48,
  parameter int inst_ram_addr_width_p = 8,
  parameter int inst_ram_els_p        = 256,
  parameter int cfg_link_addr_width_p = 16,
  parameter int cfg_link_data_width_p = 32
) (
  input  logic                             clk_i,
  input  logic                             reset_i,

  input  logic [cfg_link_addr_width_p-2:0] config_addr_i,
  input  logic [cfg_link_data_width_p-1:0] config_data_i,
  input  logic                             config_v_i,
  input  logic                             config_w_i,
  output logic                             config_ready_o,

  output logic [cfg_link_data_width_p-1:0] config_data_o,
  output logic                             config_v_o,
  input  logic                             config_ready_i,

  output logic                             inst_ram_v_o,
  output logic                             inst_ram_w_o,
  output logic [inst_ram_addr_width_p-1:0] inst_ram_addr_o,
  output logic [inst_width_p-1:0]          inst_ram_data_o,
  input  logic [inst_width_p-1:0]          inst_ram_data_i,

  output logic                             cce_mode_o,
  output logic                             cfg_err_o,

  output logic [1:0]                       state_o
);

  // Handshakes: a request transfers on a clock edge where config_v_i and
  // config_ready_o are both high; a read response transfers on an edge where
  // config_v_o and config_ready_i are both high. Valid never depends on ready.

  localparam int hi_width_lp = inst_width_p - cfg_link_data_width_p;
  localparam int addr_w_lp   = cfg_link_addr_width_p - 1;
  localparam logic [addr_w_lp-1:0] mode_addr_lp = addr_w_lp'(2 * inst_ram_els_p);

  typedef enum logic [1:0] {
    e_idle     = 2'd0,
    e_rd_issue = 2'd1,
    e_rd_wait  = 2'd2,
    e_rd_resp  = 2'd3
  } state_e;

  state_e state_r, state_n;

  logic                             ready_en_r;
  logic [cfg_link_data_width_p-1:0] lo_r;
  logic [inst_ram_addr_width_p-1:0] lo_idx_r;
  logic                             lo_v_r;
  logic                             ram_wr_r;
  logic [inst_ram_addr_width_p-1:0] ram_addr_r;
  logic [inst_width_p-1:0]          ram_data_r;
  logic                             rd_hi_r;
  logic [cfg_link_data_width_p-1:0] resp_r;
  logic                             mode_r;
  logic                             err_r;

  // Request decode
  logic                             accept;
  logic                             is_ram;
  logic                             is_mode;
  logic                             half_hi;
  logic [inst_ram_addr_width_p-1:0] req_idx;
  logic                             wr_lo, wr_hi, wr_mode, pair_ok;
  logic                             rd_ram, rd_other;

  assign accept   = config_v_i & config_ready_o;
  assign is_ram   = (config_addr_i < mode_addr_lp);
  assign is_mode  = (config_addr_i == mode_addr_lp);
  assign half_hi  = config_addr_i[0];
  assign req_idx  = config_addr_i[1 +: inst_ram_addr_width_p];

  assign wr_lo    = accept &  config_w_i & is_ram & ~half_hi;
  assign wr_hi    = accept &  config_w_i & is_ram &  half_hi;
  assign wr_mode  = accept &  config_w_i & is_mode;
  assign rd_ram   = accept & ~config_w_i & is_ram;
  assign rd_other = accept & ~config_w_i & ~is_ram;
  assign pair_ok  = lo_v_r & (lo_idx_r == req_idx);

  // FSM: state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle: begin
        if (rd_ram)        state_n = e_rd_issue;
        else if (rd_other) state_n = e_rd_resp;
      end
      e_rd_issue: state_n = e_rd_wait;
      e_rd_wait:  state_n = e_rd_resp;
      e_rd_resp:  if (config_ready_i) state_n = e_idle;
      default:    state_n = e_idle;
    endcase
  end

  // FSM: outputs. The pending pair write only ever lands in a cycle where the
  // FSM is idle, so it cannot collide with the read access in RD_ISSUE.
  always_comb begin
    config_ready_o = 1'b0;
    config_v_o     = 1'b0;
    inst_ram_v_o   = ram_wr_r;
    inst_ram_w_o   = ram_wr_r;
    unique case (state_r)
      e_idle:     config_ready_o = ready_en_r;
      e_rd_issue: begin
        inst_ram_v_o = 1'b1;
        inst_ram_w_o = 1'b0;
      end
      e_rd_resp:  config_v_o = 1'b1;
      default:    ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_en_r <= 1'b0;
      lo_r       <= '0;
      lo_idx_r   <= '0;
      lo_v_r     <= 1'b0;
      ram_wr_r   <= 1'b0;
      ram_addr_r <= '0;
      ram_data_r <= '0;
      rd_hi_r    <= 1'b0;
      resp_r     <= '0;
      mode_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      ram_wr_r   <= wr_hi & pair_ok;

      if (wr_lo) begin
        lo_r     <= config_data_i;
        lo_idx_r <= req_idx;
        lo_v_r   <= 1'b1;
      end

      // An orphan or mismatched hi half is dropped but leaves any pending lo intact
      if (wr_hi) begin
        if (pair_ok) begin
          ram_addr_r <= req_idx;
          ram_data_r <= {config_data_i[hi_width_lp-1:0], lo_r};
          lo_v_r     <= 1'b0;
        end else begin
          err_r <= 1'b1;
        end
      end

      if (wr_mode) mode_r <= config_data_i[0];

      if (rd_ram) begin
        ram_addr_r <= req_idx;
        rd_hi_r    <= half_hi;
      end

      if (rd_other) begin
        resp_r <= is_mode ? cfg_link_data_width_p'(mode_r) : '0;
      end

      if (state_r == e_rd_wait) begin
        resp_r <= rd_hi_r
          ? cfg_link_data_width_p'(inst_ram_data_i[inst_width_p-1:cfg_link_data_width_p])
          : inst_ram_data_i[cfg_link_data_width_p-1:0];
      end
    end
  end

  assign config_data_o   = resp_r;
  assign inst_ram_addr_o = ram_addr_r;
  assign inst_ram_data_o = ram_data_r;
  assign cce_mode_o      = mode_r;
  assign cfg_err_o       = err_r;
  assign state_o         = state_r;

endmodule

// File: tb/tb_bp_cce_cfg_link_slave.sv
// Bench for bp_cce_cfg_link_slave: directed scenarios followed by random traffic,
// checked against a pairing/image model of the config link and a behavioural RAM.
module tb_bp_cce_cfg_link_slave;

  localparam int IW = 48;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CAW = 15;
  localparam logic [CAW-1:0] MODE_ADDR = 15'd512;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [CAW-1:0] config_addr_i = '0;
  logic [DW-1:0]  config_data_i = '0;
  logic           config_v_i = 1'b0;
  logic           config_w_i = 1'b0;
  logic           config_ready_o;
  logic [DW-1:0]  config_data_o;
  logic           config_v_o;
  logic           config_ready_i = 1'b0;
  logic           inst_ram_v_o;
  logic           inst_ram_w_o;
  logic [AW-1:0]  inst_ram_addr_o;
  logic [IW-1:0]  inst_ram_data_o;
  logic [IW-1:0]  inst_ram_data_i;
  logic           cce_mode_o;
  logic           cfg_err_o;
  logic [1:0]     state_o;

  bp_cce_cfg_link_slave dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .config_addr_i  (config_addr_i),
    .config_data_i  (config_data_i),
    .config_v_i     (config_v_i),
    .config_w_i     (config_w_i),
    .config_ready_o (config_ready_o),
    .config_data_o  (config_data_o),
    .config_v_o     (config_v_o),
    .config_ready_i (config_ready_i),
    .inst_ram_v_o   (inst_ram_v_o),
    .inst_ram_w_o   (inst_ram_w_o),
    .inst_ram_addr_o(inst_ram_addr_o),
    .inst_ram_data_o(inst_ram_data_o),
    .inst_ram_data_i(inst_ram_data_i),
    .cce_mode_o     (cce_mode_o),
    .cfg_err_o      (cfg_err_o),
    .state_o        (state_o)
  );

  // Behavioural single-port instruction RAM, one-cycle read latency
  logic [IW-1:0] ram_mem [256];
  logic [IW-1:0] ram_rd_q = '0;
  assign inst_ram_data_i = ram_rd_q;
  always @(posedge clk_i) begin
    if (inst_ram_v_o) begin
      if (inst_ram_w_o) ram_mem[inst_ram_addr_o] <= inst_ram_data_o;
      else              ram_rd_q <= ram_mem[inst_ram_addr_o];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [IW-1:0]    ref_mem [256];
  logic [DW-1:0]    lo_m;
  logic [AW-1:0]    lo_idx_m;
  logic             lo_v_m = 1'b0;
  logic             mode_m = 1'b0;
  logic             err_m = 1'b0;
  logic [AW+IW-1:0] exp_q[$];
  logic             chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: an expected RAM write must appear exactly now, otherwise none
  always @(negedge clk_i) begin
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        logic [AW+IW-1:0] e;
        e = exp_q.pop_front();
        check("ram_wr_en",   {inst_ram_v_o, inst_ram_w_o}, 2'b11);
        check("ram_wr_addr", inst_ram_addr_o, e[IW +: AW]);
        check("ram_wr_data", inst_ram_data_o, e[IW-1:0]);
      end else begin
        check("ram_no_wr", inst_ram_w_o, 1'b0);
      end
      check("cce_mode", cce_mode_o, mode_m);
      check("cfg_err",  cfg_err_o,  err_m);
    end
  end

  // Applies one config request to the model at its acceptance edge
  task automatic model_write(input logic [CAW-1:0] addr, input logic [DW-1:0] data);
    logic [AW-1:0] idx;
    idx = addr[AW:1];
    if (addr < MODE_ADDR) begin
      if (!addr[0]) begin
        lo_m = data; lo_idx_m = idx; lo_v_m = 1'b1;
      end else if (lo_v_m && lo_idx_m == idx) begin
        ref_mem[idx] = {data[IW-DW-1:0], lo_m};
        exp_q.push_back({idx, ref_mem[idx]});
        lo_v_m = 1'b0;
      end else begin
        err_m = 1'b1;
      end
    end else if (addr == MODE_ADDR) begin
      mode_m = data[0];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int tries = 0;
    while (!config_ready_o && tries < 20) begin
      @(negedge clk_i);
      tries++;
    end
    check(tag, (tries < 20), 1'b1);
  endtask

  task automatic cfg_write(input logic [CAW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk_i);
    config_addr_i = addr; config_data_i = data; config_w_i = 1'b1; config_v_i = 1'b1;
    wait_ready("wr_ready_timeout");
    @(posedge clk_i);
    model_write(addr, data);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      config_v_i = 1'b0; config_w_i = 1'b0;
    end
  endtask

  task automatic cfg_read(input logic [CAW-1:0] addr, input int hold, output logic [DW-1:0] obs);
    logic [DW-1:0] exp_d;
    int exp_lat, lat;
    if (addr < MODE_ADDR) begin
      exp_d = addr[0] ? DW'(ref_mem[addr[AW:1]][IW-1:DW]) : ref_mem[addr[AW:1]][DW-1:0];
      exp_lat = 3;
    end else begin
      exp_d = (addr == MODE_ADDR) ? DW'(mode_m) : '0;
      exp_lat = 1;
    end
    @(negedge clk_i);
    config_addr_i = addr; config_data_i = $urandom; config_w_i = 1'b0; config_v_i = 1'b1;
    wait_ready("rd_ready_timeout");
    @(posedge clk_i);
    @(negedge clk_i);
    config_v_i = 1'b0;
    lat = 1;
    while (!config_v_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    check("rd_latency", lat, exp_lat);
    check("rd_data", config_data_o, exp_d);
    obs = config_data_o;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      check("rd_hold_v", config_v_o, 1'b1);
      check("rd_hold_data", config_data_o, exp_d);
      check("rd_hold_ready", config_ready_o, 1'b0);
    end
    config_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    config_ready_i = 1'b0;
    check("rd_resp_drop", config_v_o, 1'b0);
    check("rd_ready_back", config_ready_o, 1'b1);
  endtask

  // Asserts reset at the current time (caller sits at a negedge)
  task automatic apply_reset();
    chk_en = 1'b0;
    reset_i = 1'b1;
    config_v_i = 1'b0; config_w_i = 1'b0; config_ready_i = 1'b0;
    lo_v_m = 1'b0; err_m = 1'b0; mode_m = 1'b0;
    exp_q.delete();
    #1;
    check("rst_ready", config_ready_o, 1'b0);
    check("rst_v",     config_v_o, 1'b0);
    check("rst_data",  config_data_o, '0);
    check("rst_ram",   {inst_ram_v_o, inst_ram_w_o}, 2'b00);
    check("rst_addr",  inst_ram_addr_o, '0);
    check("rst_wdata", inst_ram_data_o, '0);
    check("rst_mode",  cce_mode_o, 1'b0);
    check("rst_err",   cfg_err_o, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    #2 reset_i = 1'b0;
    @(posedge clk_i);
    #1 check("rst_ready_rise", config_ready_o, 1'b1);
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rd;
    logic [AW-1:0] last_lo;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end

    @(negedge clk_i);
    apply_reset();

    // Sequential load, back-to-back
    for (int i = 0; i < 256; i++) begin
      cfg_write(CAW'(2*i),   32'hA5A5_0000 + 32'(i));
      cfg_write(CAW'(2*i+1), 32'h0000_1000 + 32'(i));
    end
    idle(2);
    check("load_err", cfg_err_o, 1'b0);

    // Readback of idx 3 hi with a stalled consumer
    cfg_read(15'd7, 5, rd);
    check("readback_idx3_hi", rd, 32'h0000_1003);
    cfg_read(15'd6, 0, rd);
    check("readback_idx3_lo", rd, 32'hA5A5_0003);

    // Pairing error: lo idx 4, hi idx 5, then hi idx 4 still writes
    cfg_write(15'd8,  32'h1111_2222);
    cfg_write(15'd11, 32'h0000_3333);
    idle(1);
    check("pair_err_set", cfg_err_o, 1'b1);
    cfg_write(15'd9, 32'hFFFF_4444);
    idle(2);
    check("pair_err_sticky", cfg_err_o, 1'b1);
    cfg_read(15'd9, 0, rd);
    check("pair_late_hi", rd, 32'h0000_4444);
    cfg_read(15'd8, 0, rd);
    check("pair_late_lo", rd, 32'h1111_2222);

    // Mode register and unmapped space
    cfg_write(MODE_ADDR, 32'h0000_0001);
    idle(1);
    check("mode_set", cce_mode_o, 1'b1);
    cfg_read(MODE_ADDR, 1, rd);
    check("mode_read", rd, 32'h1);
    cfg_write(15'd600, 32'hDEAD_BEEF);
    cfg_read(15'd600, 0, rd);
    check("unmapped_read", rd, 32'h0);

    // Reset between halves discards the pending lo
    cfg_write(15'd18, 32'h9999_0009);
    @(negedge clk_i);
    apply_reset();
    cfg_write(15'd19, 32'h0000_0009);
    idle(2);
    check("rst_orphan_hi_err", cfg_err_o, 1'b1);

    // Reset while the read is waiting on RAM data
    @(negedge clk_i);
    config_addr_i = 15'd20; config_w_i = 1'b0; config_v_i = 1'b1;
    wait_ready("rdwait_ready_timeout");
    @(posedge clk_i);
    @(negedge clk_i);
    config_v_i = 1'b0;
    @(negedge clk_i);
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("rdwait_no_resp", config_v_o, 1'b0);
    end

    // Random traffic
    last_lo = '0;
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [AW-1:0] idx;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        idx = AW'($urandom_range(0, 255));
        last_lo = idx;
        cfg_write({6'b0, idx, 1'b0}, $urandom);
      end else if (r < 65) begin
        idx = ($urandom_range(0, 4) != 0) ? last_lo : AW'($urandom_range(0, 255));
        cfg_write({6'b0, idx, 1'b1}, $urandom);
      end else if (r < 85) begin
        cfg_read(CAW'($urandom_range(0, 511)), $urandom_range(0, 3), rd);
      end else if (r < 90) begin
        cfg_write(MODE_ADDR, $urandom);
      end else if (r < 95) begin
        cfg_read(MODE_ADDR, $urandom_range(0, 2), rd);
      end else if (r < 98) begin
        cfg_read(CAW'($urandom_range(513, 32767)), 0, rd);
      end else begin
        cfg_write(CAW'($urandom_range(513, 32767)), $urandom);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    // Final image sweep over a few random entries
    for (int k = 0; k < 8; k++) begin
      cfg_read(CAW'($urandom_range(0, 511)), 0, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
